// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one-word lines and a single
// outstanding miss to the memory controller.
module icache #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        clear,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic        inst_miss,
    output logic [31:0] pc,
    input  logic        inst_rdy,
    input  logic [31:0] inst_in
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t state, next_state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    logic [IDX_W-1:0] idx, pc_idx;
    logic [TAG_W-1:0] tag, pc_tag;
    logic hit, hit_req, miss_req, fill, deliver;

    assign idx    = fetch_pc[IDX_W+1:2];
    assign tag    = fetch_pc[31:IDX_W+2];
    assign pc_idx = pc[IDX_W+1:2];
    assign pc_tag = pc[31:IDX_W+2];
    assign hit    = valid[idx] && (tags[idx] == tag);

    // Dropping inst_miss on the completion cycle keeps the controller from restarting.
    assign inst_miss = (state == MISS) && !inst_rdy;

    always_comb begin
        fill       = (state == MISS) && inst_rdy;
        hit_req    = (state == IDLE) && fetch_valid && !clear && hit;
        miss_req   = (state == IDLE) && fetch_valid && !clear && !hit;
        deliver    = hit_req || (fill && !clear);
        next_state = (clear || fill) ? IDLE : miss_req ? MISS : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else if (rdy)
            state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            pc        <= '0;
            valid     <= '0;
        end else begin
            out_valid <= rdy && deliver;
            if (rdy) begin
                if (hit_req)
                    out_inst <= data[idx];
                else if (fill && !clear)
                    out_inst <= inst_in;
                if (miss_req)
                    pc <= fetch_pc & ~32'd3;
                if (fill)
                    valid[pc_idx] <= 1'b1;
            end
        end
    end

    // A fill still lands when clear arrives with inst_rdy; only the delivery is cancelled.
    always_ff @(posedge clk) begin
        if (rst_n && rdy && fill) begin
            tags[pc_idx] <= pc_tag;
            data[pc_idx] <= inst_in;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache with hand-computed expectations.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst_n, rdy, fetch_valid, clear, inst_rdy;
    logic [31:0] fetch_pc, inst_in;
    logic        out_valid, inst_miss;
    logic [31:0] out_inst, pc;
    int checks = 0;
    int errors = 0;

    icache #(.IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc), .clear(clear), .out_valid(out_valid),
        .out_inst(out_inst), .inst_miss(inst_miss), .pc(pc),
        .inst_rdy(inst_rdy), .inst_in(inst_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] addr);
        fetch_valid = 1'b1;
        fetch_pc    = addr;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic complete(input logic [31:0] word);
        inst_rdy = 1'b1;
        inst_in  = word;
        step();
        inst_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 0; rdy = 1; fetch_valid = 0; clear = 0; inst_rdy = 0;
        fetch_pc = 0; inst_in = 0;
        step(); step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_inst_miss", {31'b0, inst_miss}, 32'd0);
        rst_n = 1;

        // cold miss on 0x4
        req(32'h4);
        check("cold_inst_miss", {31'b0, inst_miss}, 32'd1);
        check("cold_pc", pc, 32'h4);
        check("cold_no_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("cold_wait_miss", {31'b0, inst_miss}, 32'd1);
        inst_rdy = 1; inst_in = 32'h0051_0113; #1;
        check("miss_drop_on_rdy", {31'b0, inst_miss}, 32'd0);
        step(); inst_rdy = 0;
        check("cold_out_valid", {31'b0, out_valid}, 32'd1);
        check("cold_out_inst", out_inst, 32'h0051_0113);
        step();
        check("pulse_one_cycle", {31'b0, out_valid}, 32'd0);
        check("out_inst_hold", out_inst, 32'h0051_0113);

        // hit and back-to-back hits
        req(32'h4);
        check("hit_valid", {31'b0, out_valid}, 32'd1);
        check("hit_inst", out_inst, 32'h0051_0113);
        check("hit_no_miss", {31'b0, inst_miss}, 32'd0);
        req(32'h8);
        check("fill8_pc", pc, 32'h8);
        complete(32'hAAAA_0008);
        check("fill8_inst", out_inst, 32'hAAAA_0008);
        fetch_valid = 1; fetch_pc = 32'h4; step();
        check("b2b_valid0", {31'b0, out_valid}, 32'd1);
        check("b2b_inst0", out_inst, 32'h0051_0113);
        fetch_pc = 32'h8; step();
        check("b2b_valid1", {31'b0, out_valid}, 32'd1);
        check("b2b_inst1", out_inst, 32'hAAAA_0008);
        fetch_valid = 0; step();
        check("b2b_end", {31'b0, out_valid}, 32'd0);

        // conflict: 0x104 shares index 1 with 0x4
        req(32'h104);
        check("conf_miss", {31'b0, inst_miss}, 32'd1);
        check("conf_pc", pc, 32'h104);
        complete(32'h1111_0104);
        check("conf_inst", out_inst, 32'h1111_0104);
        req(32'h4);
        check("evicted_miss", {31'b0, inst_miss}, 32'd1);
        complete(32'h0051_0113);
        check("refill_inst", out_inst, 32'h0051_0113);

        // clear mid-miss
        req(32'hC);
        check("c_miss", {31'b0, inst_miss}, 32'd1);
        clear = 1; step(); clear = 0;
        check("clear_drop_miss", {31'b0, inst_miss}, 32'd0);
        check("clear_no_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("clear_no_valid2", {31'b0, out_valid}, 32'd0);
        req(32'hC);
        check("after_clear_miss", {31'b0, inst_miss}, 32'd1);

        // rdy stall during miss
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_miss", {31'b0, inst_miss}, 32'd1);
            check("stall_pc", pc, 32'hC);
            check("stall_valid", {31'b0, out_valid}, 32'd0);
        end
        rdy = 1;
        complete(32'hCCCC_000C);
        check("stall_fill_valid", {31'b0, out_valid}, 32'd1);
        check("stall_fill_inst", out_inst, 32'hCCCC_000C);

        // clear together with inst_rdy: line filled, nothing delivered
        req(32'h10);
        clear = 1; complete(32'h1010_1010); clear = 0;
        check("clrfill_no_valid", {31'b0, out_valid}, 32'd0);
        check("clrfill_hold", out_inst, 32'hCCCC_000C);
        req(32'h10);
        check("clrfill_hit", {31'b0, out_valid}, 32'd1);
        check("clrfill_hit_inst", out_inst, 32'h1010_1010);
        check("clrfill_no_miss", {31'b0, inst_miss}, 32'd0);

        // clear with fetch in IDLE drops the request
        clear = 1; req(32'h4); clear = 0;
        check("clrfetch_valid", {31'b0, out_valid}, 32'd0);
        check("clrfetch_miss", {31'b0, inst_miss}, 32'd0);

        // reset mid-miss with inst_rdy high
        req(32'h14);
        check("pre_rst_miss", {31'b0, inst_miss}, 32'd1);
        rst_n = 0; inst_rdy = 1; inst_in = 32'hDEAD_BEEF; step();
        check("rstmiss_valid", {31'b0, out_valid}, 32'd0);
        check("rstmiss_inst", out_inst, 32'd0);
        check("rstmiss_pc", pc, 32'd0);
        rst_n = 1; step(); inst_rdy = 0;
        check("late_rdy_valid", {31'b0, out_valid}, 32'd0);
        check("late_rdy_miss", {31'b0, inst_miss}, 32'd0);

        // reset during a pending hit
        req(32'h4);
        check("prehit_valid", {31'b0, out_valid}, 32'd0);
        check("prehit_miss", {31'b0, inst_miss}, 32'd1);
        complete(32'h0051_0113);
        fetch_valid = 1; fetch_pc = 32'h4; rst_n = 0; step();
        fetch_valid = 0; rst_n = 1;
        check("rsthit_valid", {31'b0, out_valid}, 32'd0);
        check("rsthit_inst", out_inst, 32'd0);
        req(32'h4);
        check("post_rst_miss", {31'b0, inst_miss}, 32'd1);
        check("post_rst_pc", pc, 32'h4);
        clear = 1; step(); clear = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: IDX_W, default 6, index width; 2^IDX_W direct-mapped one-word lines.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 rdy  input  1  global enable; low freezes all state.
REQ-005 fetch_valid  input  1  fetch-stage request strobe.
REQ-006 fetch_pc  input  32  request byte address; word-aligned.
REQ-007 clear  input  1  flush request from branch/jump redirect; cancels in-flight fetch.
REQ-008 out_valid  output  1  one-cycle pulse; out_inst valid.
REQ-009 out_inst  output  32  fetched instruction word.
REQ-010 inst_miss  output  1  memory-controller fetch request; must stay high for the whole fetch.
REQ-011 pc  output  32  word address sent to memory controller.
REQ-012 inst_rdy  input  1  memory-controller one-cycle completion pulse.
REQ-013 inst_in  input  32  fetched word, valid while inst_rdy high.

Function
REQ-014 Address split: bits [1:0] ignored; index = fetch_pc[IDX_W+1:2]; tag = fetch_pc[31:IDX_W+2].
REQ-015 Storage per line: valid bit, tag, 32-bit data word.
REQ-016 FSM states: IDLE and MISS.
REQ-017 IDLE, fetch_valid=1, hit (valid and tag match):
- next cycle out_valid=1 and out_inst=line data;
- state stays IDLE;
- back-to-back hits are accepted every cycle.
REQ-018 IDLE, fetch_valid=1, miss:
- next cycle state=MISS;
- pc register loaded with {fetch_pc[31:2],2'b00};
- out_valid=0.
REQ-019 inst_miss = (state==MISS) and not inst_rdy, combinational, so the controller never restarts a fetch on the completion cycle.
REQ-020 MISS with inst_rdy=1:
- line[index of pc] written with valid=1, tag of pc, data=inst_in;
- next cycle out_valid=1, out_inst=inst_in, state=IDLE.
REQ-021 MISS: fetch_valid and fetch_pc are ignored; the requester holds its request until out_valid.
REQ-022 clear=1 in any state:
- next cycle state=IDLE and out_valid=0;
- in MISS, inst_miss drops the following cycle, which aborts the controller.
REQ-023 clear and inst_rdy high in the same cycle: line is still filled; no out_valid is produced.
REQ-024 clear and fetch_valid high in IDLE in the same cycle: request is dropped.
REQ-025 clear does not invalidate cache lines.
REQ-026 rdy=0:
- state, pc, tags and lines are held;
- out_valid forced to 0 next cycle;
- inst_miss keeps its value.
REQ-027 out_valid is high for exactly one cycle per accepted, uncleared request.
REQ-028 out_inst holds its last value when out_valid=0.
REQ-029 Hit latency is 1 cycle. Miss latency is 1 cycle plus controller latency (inst_rdy cycle + 1).

Reset
REQ-030 When rst_n=0 at a clock edge:
- all valid bits cleared;
- state=IDLE;
- out_valid=0, out_inst=0;
- pc=0, inst_miss=0.
REQ-031 Reset takes priority over rdy, clear and inst_rdy.
REQ-032 Reset mid-MISS abandons the fetch with no line written; a late inst_rdy after reset is ignored.

Verification
REQ-033 Cold miss:
- fetch_pc=0x0000_0004 after reset -> inst_miss=1 and pc=0x4 next cycle;
- inst_rdy with inst_in=0x0051_0113 -> out_valid=1, out_inst=0x0051_0113 next cycle, then IDLE.
REQ-034 Hit:
- re-request 0x4 -> out_valid next cycle, same data, inst_miss stays 0;
- 0x4 and 0x8 (both filled) on consecutive cycles -> two consecutive out_valid pulses.
REQ-035 Conflict with IDX_W=6: fill 0x0000_0004, then request 0x0000_0104 -> miss; after fill, 0x4 misses again.
REQ-036 Clear mid-miss: clear during MISS -> inst_miss low within 1 cycle, no out_valid; a later request to the same address misses.
REQ-037 rdy stall: rdy low for 3 cycles during MISS -> state and pc unchanged, inst_miss held; fill completes normally after rdy returns.
REQ-038 Reset: rst_n low during MISS and then during a pending hit -> all outputs 0 next cycle; previously filled address misses.
